// File: rtl/ds_adc_readout_scheduler_if.sv
// Channel-side and serial-side signals of the ADC readout scheduler.
// The bench or upstream logic drives the master side; the scheduler uses the slave side.
interface ds_adc_readout_scheduler_if #(
  parameter int unsigned NCH   = 3,
  parameter int unsigned WIDTH = 16
);
  logic                 trigger;
  logic [NCH-1:0]       ch_valid;
  logic [NCH*WIDTH-1:0] ch_data;
  logic [NCH-1:0]       ch_mask;
  logic                 clr_status;
  logic                 serial_out;
  logic                 frame_sync;
  logic                 busy;
  logic                 done;
  logic [NCH-1:0]       overrun;
  logic                 trig_dropped;

  modport master (
    output trigger, ch_valid, ch_data, ch_mask, clr_status,
    input  serial_out, frame_sync, busy, done, overrun, trig_dropped
  );

  modport slave (
    input  trigger, ch_valid, ch_data, ch_mask, clr_status,
    output serial_out, frame_sync, busy, done, overrun, trig_dropped
  );
endinterface

// File: rtl/ds_adc_readout_scheduler.sv
// Shares one serial pin between NCH decimated ADC channels: holds the latest words,
// snapshots them on an external trigger and streams framed channel words in index order.
module ds_adc_readout_scheduler #(
  parameter int unsigned NCH   = 3,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned GAP   = 2
) (
  input logic                       clk,
  input logic                       rst_n,
  ds_adc_readout_scheduler_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 16);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StId,
    StFresh,
    StData,
    StGap,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic trig_s1_q, trig_s2_q, trig_s3_q;
  logic trig_edge;

  // Storage is sized for the maximum of four channels so the 2-bit index never overruns.
  logic [WIDTH-1:0] hold_q   [4];
  logic [WIDTH-1:0] shadow_q [4];
  logic [3:0]       fresh_q;
  logic [3:0]       fstat_q;

  logic [3:0]       pend_q, pend_d;
  logic [3:0]       rest;
  logic [1:0]       cur;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             snap;
  logic             drop;

  logic [NCH-1:0]   consume;
  logic [NCH-1:0]   ovr_set;
  logic [NCH-1:0]   overrun_q;
  logic             trig_drop_q;

  logic so_q, so_d;
  logic fs_q, fs_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  // Pad trigger: two-flop synchroniser plus one flop for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_s1_q <= 1'b0;
      trig_s2_q <= 1'b0;
      trig_s3_q <= 1'b0;
    end else begin
      trig_s1_q <= bus.trigger;
      trig_s2_q <= trig_s1_q;
      trig_s3_q <= trig_s2_q;
    end
  end

  assign trig_edge = trig_s2_q & ~trig_s3_q;

  // Lowest pending channel index; the loop runs downward so the lowest set bit wins.
  always_comb begin
    cur = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pend_q[i]) begin
        cur = 2'(i);
      end
    end
  end

  // A sample arriving in the snapshot cycle is not an overwrite of the consumed word.
  always_comb begin
    consume = snap ? bus.ch_mask : '0;
    ovr_set = bus.ch_valid & fresh_q[NCH-1:0] & ~consume;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        hold_q[i]   <= '0;
        shadow_q[i] <= '0;
      end
      fresh_q <= '0;
      fstat_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (bus.ch_valid[i]) begin
          hold_q[i]  <= bus.ch_data[i*WIDTH +: WIDTH];
          fresh_q[i] <= 1'b1;
        end else if (consume[i]) begin
          fresh_q[i] <= 1'b0;
        end
        if (snap) begin
          shadow_q[i] <= hold_q[i];
          fstat_q[i]  <= fresh_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q   <= '0;
      trig_drop_q <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (ovr_set[i]) begin
          overrun_q[i] <= 1'b1;
        end else if (bus.clr_status) begin
          overrun_q[i] <= 1'b0;
        end
      end
      if (drop) begin
        trig_drop_q <= 1'b1;
      end else if (bus.clr_status) begin
        trig_drop_q <= 1'b0;
      end
    end
  end

  // Outputs are registered from the current state, so the stream lags the FSM by one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    sr_d    = sr_q;
    rest    = pend_q;
    snap    = 1'b0;
    so_d    = 1'b0;
    fs_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    drop    = trig_edge && (state_q != StIdle);

    case (state_q)
      StIdle: begin
        if (trig_edge) begin
          snap    = 1'b1;
          pend_d  = 4'(bus.ch_mask);
          state_d = (bus.ch_mask != '0) ? StStart : StDone;
        end
      end
      StStart: begin
        so_d    = 1'b1;
        fs_d    = 1'b1;
        busy_d  = 1'b1;
        sr_d    = shadow_q[cur];
        cnt_d   = '0;
        state_d = StId;
      end
      StId: begin
        so_d   = cnt_q[0] ? cur[0] : cur[1];
        busy_d = 1'b1;
        if (cnt_q[0]) begin
          cnt_d   = '0;
          state_d = StFresh;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StFresh: begin
        so_d    = fstat_q[cur];
        busy_d  = 1'b1;
        cnt_d   = '0;
        state_d = StData;
      end
      StData: begin
        so_d   = sr_q[WIDTH-1];
        busy_d = 1'b1;
        sr_d   = sr_q << 1;
        if (cnt_q == CntW'(WIDTH - 1)) begin
          rest   = pend_q & ~(4'b0001 << cur);
          pend_d = rest;
          cnt_d  = '0;
          if (rest == 4'b0000) begin
            state_d = StDone;
          end else if (GAP == 0) begin
            state_d = StStart;
          end else begin
            state_d = StGap;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StGap: begin
        busy_d = 1'b1;
        if (cnt_q == CntW'(GAP - 1)) begin
          cnt_d   = '0;
          state_d = StStart;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pend_q  <= '0;
      sr_q    <= '0;
      so_q    <= 1'b0;
      fs_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      sr_q    <= sr_d;
      so_q    <= so_d;
      fs_q    <= fs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.serial_out   = so_q;
  assign bus.frame_sync   = fs_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.overrun      = overrun_q;
  assign bus.trig_dropped = trig_drop_q;

endmodule

// File: tb/tb_ds_adc_readout_scheduler.sv
// Scoreboard bench for ds_adc_readout_scheduler: each trigger queues the expected serial
// stream, and a negedge monitor pops and compares it when done pulses.
module tb_ds_adc_readout_scheduler;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ds_adc_readout_scheduler_if #(.NCH(3), .WIDTH(16)) bus ();

  ds_adc_readout_scheduler #(.NCH(3), .WIDTH(16), .GAP(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [127:0] bits;
    int           len;
    int           fs;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          done_count = 0;
  int          done_base = 0;
  logic [15:0] mdl_hold [3];
  logic [2:0]  mdl_fresh;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t push_bit(input exp_t e, input logic b);
    exp_t r;
    r      = e;
    r.bits = {e.bits[126:0], b};
    r.len  = e.len + 1;
    return r;
  endfunction

  // Expected stream: per channel 1, id[1:0], fresh, data MSB first; two zeros between frames.
  function automatic exp_t build(input logic [2:0] mask);
    exp_t        e;
    logic        first;
    logic [1:0]  id;
    logic [15:0] d;
    e     = '0;
    first = 1'b1;
    for (int ch = 0; ch < 3; ch++) begin
      if (mask[ch]) begin
        if (!first) begin
          e = push_bit(e, 1'b0);
          e = push_bit(e, 1'b0);
        end
        id = 2'(ch);
        d  = mdl_hold[ch];
        e  = push_bit(e, 1'b1);
        e  = push_bit(e, id[1]);
        e  = push_bit(e, id[0]);
        e  = push_bit(e, mdl_fresh[ch]);
        for (int b = 15; b >= 0; b--) e = push_bit(e, d[b]);
        e.fs  = e.fs + 1;
        first = 1'b0;
      end
    end
    return e;
  endfunction

  task automatic load(input logic [2:0] v, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] c, input logic clr);
    bus.ch_valid   = v;
    bus.ch_data    = {c, b, a};
    bus.clr_status = clr;
    tick();
    bus.ch_valid   = '0;
    bus.clr_status = 1'b0;
    if (v[0]) begin mdl_hold[0] = a; mdl_fresh[0] = 1'b1; end
    if (v[1]) begin mdl_hold[1] = b; mdl_fresh[1] = 1'b1; end
    if (v[2]) begin mdl_hold[2] = c; mdl_fresh[2] = 1'b1; end
  endtask

  // Two-cycle trigger pulse; checks the start bit (or empty-mask done) lands after edge k+3.
  task automatic readout(input logic [2:0] mask, input bit expect_it);
    exp_t e;
    e = build(mask);
    if (expect_it) exp_q.push_back(e);
    mdl_fresh   = mdl_fresh & ~mask;
    done_base   = done_count;
    bus.ch_mask = mask;
    bus.trigger = 1'b1;
    tick();
    tick();
    bus.trigger = 1'b0;
    tick();
    check("pre_start_quiet", {125'd0, bus.serial_out, bus.frame_sync, bus.done}, 128'd0);
    tick();
    if (mask != 3'b000)
      check("start_bit", {125'd0, bus.serial_out, bus.frame_sync, bus.busy}, 128'd7);
    else
      check("empty_done", {124'd0, bus.serial_out, bus.frame_sync, bus.busy, bus.done},
            128'd1);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_count == done_base && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (done_count == done_base) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: actual=no done required=done within %0d cycles", budget);
    end
  endtask

  // Monitor: collect serial bits while busy, compare against the queue head on done.
  initial begin
    logic [127:0] cb;
    int           cl;
    int           cf;
    int           stray;
    exp_t         e;
    cb = '0; cl = 0; cf = 0; stray = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cb = '0; cl = 0; cf = 0; stray = 0;
      end else begin
        if (bus.busy) begin
          cb = {cb[126:0], bus.serial_out};
          cl++;
          if (bus.frame_sync) cf++;
        end else if (bus.serial_out || bus.frame_sync) begin
          stray++;
        end
        if (bus.done) begin
          done_count++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done: actual=done required=no readout");
          end else begin
            e = exp_q.pop_front();
            check("stream_len", 128'(cl), 128'(e.len));
            check("stream_bits", cb, e.bits);
            check("frame_sync_count", 128'(cf), 128'(e.fs));
            check("idle_quiet", 128'(stray), 128'd0);
          end
          cb = '0; cl = 0; cf = 0; stray = 0;
        end
      end
    end
  end

  initial begin
    rst_n          = 1'b0;
    bus.trigger    = 1'b0;
    bus.ch_valid   = '0;
    bus.ch_data    = '0;
    bus.ch_mask    = '0;
    bus.clr_status = 1'b0;
    mdl_fresh      = '0;
    for (int i = 0; i < 3; i++) mdl_hold[i] = '0;

    repeat (3) tick();
    check("reset_outputs", {120'd0, bus.serial_out, bus.frame_sync, bus.busy, bus.done,
                            bus.overrun, bus.trig_dropped}, 128'd0);
    rst_n = 1'b1;
    tick();

    // Full three-channel readout.
    load(3'b111, 16'hA5C3, 16'h0F0F, 16'h9696, 1'b0);
    readout(3'b111, 1'b1);
    wait_done(200);
    check("overrun_after_t1", {125'd0, bus.overrun}, 128'd0);

    // Single stale channel.
    readout(3'b010, 1'b1);
    wait_done(200);

    // Overrun set, clear, and set-wins-over-clear.
    load(3'b001, 16'h1111, 16'h0, 16'h0, 1'b0);
    check("overrun_first", {125'd0, bus.overrun}, 128'd0);
    load(3'b001, 16'h2222, 16'h0, 16'h0, 1'b0);
    check("overrun_second", {125'd0, bus.overrun}, 128'd1);
    load(3'b000, 16'h0, 16'h0, 16'h0, 1'b1);
    check("overrun_clear", {125'd0, bus.overrun}, 128'd0);
    load(3'b001, 16'h3333, 16'h0, 16'h0, 1'b1);
    check("overrun_set_wins", {125'd0, bus.overrun}, 128'd1);
    load(3'b000, 16'h0, 16'h0, 16'h0, 1'b1);

    // Trigger during a readout is dropped, not queued.
    readout(3'b111, 1'b1);
    repeat (10) tick();
    bus.trigger = 1'b1;
    tick();
    tick();
    bus.trigger = 1'b0;
    wait_done(200);
    check("trig_dropped_set", {127'd0, bus.trig_dropped}, 128'd1);
    repeat (40) tick();
    check("single_readout", 128'(done_count - done_base), 128'd1);
    load(3'b000, 16'h0, 16'h0, 16'h0, 1'b1);
    check("trig_dropped_clear", {127'd0, bus.trig_dropped}, 128'd0);

    // Reset in the middle of channel 0 data (all ones, so serial_out is high).
    load(3'b111, 16'hFFFF, 16'h0001, 16'h8000, 1'b0);
    readout(3'b111, 1'b0);
    repeat (6) tick();
    check("pre_reset_data", {127'd0, bus.serial_out}, 128'd1);
    rst_n = 1'b0;
    #1;
    check("reset_abort", {125'd0, bus.serial_out, bus.busy, bus.frame_sync}, 128'd0);
    mdl_fresh = '0;
    for (int i = 0; i < 3; i++) mdl_hold[i] = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("post_reset_status", {124'd0, bus.overrun, bus.trig_dropped}, 128'd0);
    load(3'b111, 16'h1234, 16'h5678, 16'h9ABC, 1'b0);
    readout(3'b111, 1'b1);
    wait_done(200);

    // Empty mask: done only, never busy.
    readout(3'b000, 1'b1);
    wait_done(20);

    repeat (5) tick();
    check("queue_drained", 128'(exp_q.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
